// File: rtl/arbiter_pkg.sv
// Shared arbiter constants and helpers, used by the round-robin family of arbiters.
package arbiter_pkg;

  localparam logic ARB_MODE_RR    = 1'b0;
  localparam logic ARB_MODE_FIXED = 1'b1;

  // Select width for n requesters; a single port still gets a 1-bit select.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin / fixed-priority picker. Searches the request vector starting at
// start_i (or at port 0 in fixed mode), wrapping, using a doubled vector and find-first-one.
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned SEL_WIDTH = sel_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [SEL_WIDTH-1:0] start_i,
  input  logic                 mode_i,
  output logic [SEL_WIDTH-1:0] winner_o,
  output logic                 valid_o
);

  logic [2*NUM_PORTS-1:0] dbl;
  int                     base;
  int                     hit;

  always_comb begin
    dbl      = {req_i, req_i};
    base     = (mode_i == ARB_MODE_FIXED) ? 0 : int'(start_i);
    hit      = -1;
    winner_o = '0;
    valid_o  = |req_i;
    // The upper copy covers the wrap, so any request is found within NUM_PORTS of base.
    for (int j = 0; j < 2 * NUM_PORTS; j++) begin
      if (hit < 0 && j >= base && dbl[j]) begin
        hit = j;
      end
    end
    if (hit >= int'(NUM_PORTS)) begin
      hit = hit - int'(NUM_PORTS);
    end
    if (hit >= 0) begin
      winner_o = SEL_WIDTH'(hit);
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with burst hold credits and a run-time fixed-priority mode.
// Grant, select and active are all registered.
module wrr_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 5,
  parameter int unsigned SEL_WIDTH    = sel_width(NUM_PORTS),
  parameter int unsigned WEIGHT_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              request,
  input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight,
  input  logic                              mode,
  output logic [NUM_PORTS-1:0]              grant,
  output logic [SEL_WIDTH-1:0]              select,
  output logic                              active
);

  logic [NUM_PORTS-1:0]    grant_q, grant_d;
  logic [SEL_WIDTH-1:0]    select_q, select_d;
  logic                    active_q, active_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic [SEL_WIDTH-1:0]    ptr_q, ptr_d;

  logic                    owner_req;
  logic                    hold;
  logic [SEL_WIDTH-1:0]    start_idx;
  logic [SEL_WIDTH-1:0]    pick_idx;
  logic                    pick_valid;
  logic [WEIGHT_WIDTH-1:0] pick_weight;

  // Search begins one past the last RR winner; reset value NUM_PORTS-1 starts at port 0.
  assign start_idx = (ptr_q == SEL_WIDTH'(NUM_PORTS - 1)) ? '0 : ptr_q + SEL_WIDTH'(1);

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr_pick (
    .req_i    (request),
    .start_i  (start_idx),
    .mode_i   (mode),
    .winner_o (pick_idx),
    .valid_o  (pick_valid)
  );

  always_comb begin
    owner_req   = 1'b0;
    pick_weight = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (select_q == SEL_WIDTH'(p)) begin
        owner_req = request[p];
      end
      if (pick_idx == SEL_WIDTH'(p)) begin
        pick_weight = weight[p*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
  end

  assign hold = active_q && owner_req && (credit_q != '0);

  always_comb begin
    grant_d  = grant_q;
    select_d = select_q;
    active_d = active_q;
    credit_d = credit_q;
    ptr_d    = ptr_q;
    if (hold) begin
      credit_d = credit_q - WEIGHT_WIDTH'(1);
    end else if (pick_valid) begin
      select_d = pick_idx;
      active_d = 1'b1;
      credit_d = pick_weight;
      for (int p = 0; p < NUM_PORTS; p++) begin
        grant_d[p] = (pick_idx == SEL_WIDTH'(p));
      end
      // Fixed mode leaves the rotation where RR last left it.
      if (mode == ARB_MODE_RR) begin
        ptr_d = pick_idx;
      end
    end else begin
      grant_d  = '0;
      active_d = 1'b0;
      credit_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q  <= '0;
      select_q <= '0;
      active_q <= 1'b0;
      credit_q <= '0;
      ptr_q    <= SEL_WIDTH'(NUM_PORTS - 1);
    end else begin
      grant_q  <= grant_d;
      select_q <= select_d;
      active_q <= active_d;
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
    end
  end

  assign grant  = grant_q;
  assign select = select_q;
  assign active = active_q;

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_active_match  : assert property (@(posedge clk) disable iff (rst) active_q == (|grant_q));

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: directed scenarios plus random traffic, all outputs checked against
// a behavioural model through an expectation queue.
module tb_wrr_arbiter;

  localparam int N  = 5;
  localparam int SW = 3;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  request;
  logic [N*WW-1:0] weight;
  logic          mode;
  logic [N-1:0]  grant;
  logic [SW-1:0] select;
  logic          active;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [N-1:0]  grant;
    logic [SW-1:0] sel;
    logic          act;
    logic [WW-1:0] cred;
    logic [SW-1:0] ptr;
  } mstate_t;

  typedef struct packed {
    logic [N-1:0]  grant;
    logic [SW-1:0] sel;
    logic          act;
  } exp_t;

  mstate_t m_state;
  exp_t    exp_q[$];

  wrr_arbiter #(
    .NUM_PORTS    (N),
    .SEL_WIDTH    (SW),
    .WEIGHT_WIDTH (WW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .request (request),
    .weight  (weight),
    .mode    (mode),
    .grant   (grant),
    .select  (select),
    .active  (active)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mstate_t model_step(input mstate_t s, input logic r, input logic [N-1:0] req,
                                         input logic [N*WW-1:0] w, input logic md);
    mstate_t n;
    int      win;
    n   = s;
    win = -1;
    if (r) begin
      n     = '0;
      n.ptr = SW'(N - 1);
      return n;
    end
    if (s.act && req[s.sel] && s.cred != 0) begin
      n.cred = s.cred - 1'b1;
      return n;
    end
    if (md) begin
      for (int i = 0; i < N; i++) begin
        if (win < 0 && req[i]) win = i;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (int'(s.ptr) + k) % N;
        if (win < 0 && req[p]) win = p;
      end
    end
    if (win >= 0) begin
      n.grant      = '0;
      n.grant[win] = 1'b1;
      n.sel        = SW'(win);
      n.act        = 1'b1;
      n.cred       = w[win*WW +: WW];
      if (!md) n.ptr = SW'(win);
    end else begin
      n.grant = '0;
      n.act   = 1'b0;
      n.cred  = '0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    mstate_t nx;
    nx = model_step(m_state, rst, request, weight, mode);
    m_state <= nx;
    exp_q.push_back('{grant: nx.grant, sel: nx.sel, act: nx.act});
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("sb_grant", 32'(grant), 32'(e.grant));
      check_eq("sb_select", 32'(select), 32'(e.sel));
      check_eq("sb_active", 32'(active), 32'(e.act));
      check_eq("inv_onehot0", 32'($onehot0(grant)), 32'(1));
      check_eq("inv_active", 32'(active), 32'(|grant));
    end
  end

  initial begin
    rst     = 1'b1;
    request = 5'h1F;
    weight  = '0;
    mode    = 1'b0;

    repeat (2) begin
      @(negedge clk);
      check_eq("rst_grant", 32'(grant), 32'h0);
      check_eq("rst_active", 32'(active), 32'h0);
      check_eq("rst_select", 32'(select), 32'h0);
    end

    // Equal zero weights: one grant per cycle rotating from port 0.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("rr_grant", 32'(grant), 32'(1) << (i % 5));
    end

    // w0=2, w1=0: port 0 three cycles, port 1 one cycle.
    weight       = '0;
    weight[3:0]  = 4'd2;
    request      = 5'h03;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("wt_grant", 32'(grant), (i % 4 == 3) ? 32'h02 : 32'h01);
    end

    // Port 2 with w=7 drops its request after two cycles; port 3 follows without a gap.
    weight        = '0;
    weight[11:8]  = 4'd7;
    request       = 5'h1F;
    @(negedge clk);
    check_eq("drop_own", 32'(grant), 32'h04);
    @(negedge clk);
    check_eq("drop_hold", 32'(grant), 32'h04);
    request = 5'h1B;
    @(negedge clk);
    check_eq("drop_next", 32'(grant), 32'h08);
    check_eq("drop_active", 32'(active), 32'h1);

    // Fixed priority: port 2 starves port 4 until port 0 asks.
    mode    = 1'b1;
    weight  = '0;
    request = 5'h14;
    repeat (4) begin
      @(negedge clk);
      check_eq("fix_grant", 32'(grant), 32'h04);
    end
    request = 5'h15;
    @(negedge clk);
    check_eq("fix_preempt", 32'(grant), 32'h01);

    // Reset in the middle of a long hold by port 3.
    mode          = 1'b0;
    request       = 5'h08;
    weight        = '0;
    weight[15:12] = 4'd15;
    repeat (3) begin
      @(negedge clk);
      check_eq("hold_grant", 32'(grant), 32'h08);
    end
    rst     = 1'b1;
    request = 5'h1F;
    @(negedge clk);
    check_eq("midrst_grant", 32'(grant), 32'h0);
    check_eq("midrst_active", 32'(active), 32'h0);
    check_eq("midrst_select", 32'(select), 32'h0);
    rst    = 1'b0;
    weight = '0;
    @(negedge clk);
    check_eq("restart_grant", 32'(grant), 32'h01);

    // Random traffic, checked by the scoreboard.
    for (int i = 0; i < 600; i++) begin
      request = N'($urandom);
      for (int p = 0; p < N; p++) begin
        weight[p*WW +: WW] = WW'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      rst = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end

    rst     = 1'b0;
    request = '0;
    repeat (3) @(negedge clk);
    check_eq("idle_active", 32'(active), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
